// File: rtl/myproject_dense_acc.sv
// Purpose : dense-layer neuron accumulator: sums N_IN signed products, adds an aligned bias, rounds, shifts, saturates.
// Latency : result valid the cycle after the last-product edge; one output per N_IN+1 cycles minimum.
// Backpr. : prod_ready drops while a result is held; the result is held until out_valid & out_ready.
//
// Ports:
//   ap_clk, ap_rst        clock, synchronous active-high reset
//   prod_valid/ready/data product stream in (PROD_W signed)
//   bias_in               signed bias, taken on the last-product beat
//   out_valid/ready/data  result stream out (OUT_W signed), out_sat flags clipping
//   busy                  partial sum in progress or result pending
module myproject_dense_acc #(
  parameter int N_IN     = 16,
  parameter int PROD_W   = 31,
  parameter int ACC_W    = 36,
  parameter int BIAS_W   = 16,
  parameter int BIAS_LSH = 4,
  parameter int SHIFT    = 10,
  parameter int OUT_W    = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic [BIAS_W-1:0] bias_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              busy
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  // Rounding constant (half an output LSB) and the output range, all at accumulator width.
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] sum_rnd;
  logic signed [ACC_W-1:0] r;
  logic [CNT_W-1:0]        cnt;
  logic                    accept;
  logic                    last;
  logic                    sat_hi;
  logic                    sat_lo;

  // Accept decision is built from state and ap_rst directly so it never loops through prod_ready.
  assign accept = (state == ST_ACC) & ~ap_rst & prod_valid;
  assign last   = (cnt == CNT_LAST);

  assign prod_ext = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign bias_ext = {{(ACC_W-BIAS_W){bias_in[BIAS_W-1]}}, bias_in} << BIAS_LSH;

  // Final sum includes the current (last) product and the bias; arithmetic shift floors,
  // so adding half an LSB first rounds half toward +inf.
  assign sum     = acc + prod_ext + bias_ext;
  assign sum_rnd = sum + RND;
  assign r       = sum_rnd >>> SHIFT;
  assign sat_hi  = (r > OUT_MAX);
  assign sat_lo  = (r < OUT_MIN);

  assign busy = (cnt != '0) | (state == ST_HOLD);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    prod_ready = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_ACC: begin
        prod_ready = ~ap_rst;
        if (accept && last) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_ACC;
        end
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (accept) begin
      if (last) begin
        acc      <= '0;
        cnt      <= '0;
        out_sat  <= sat_hi | sat_lo;
        if (sat_hi) begin
          out_data <= OUT_MAX[OUT_W-1:0];
        end else if (sat_lo) begin
          out_data <= OUT_MIN[OUT_W-1:0];
        end else begin
          out_data <= r[OUT_W-1:0];
        end
      end else begin
        acc <= acc + prod_ext;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_myproject_dense_acc.sv
module tb_myproject_dense_acc;

  localparam int N_IN     = 4;
  localparam int PROD_W   = 31;
  localparam int ACC_W    = 36;
  localparam int BIAS_W   = 16;
  localparam int BIAS_LSH = 4;
  localparam int SHIFT    = 10;
  localparam int OUT_W    = 16;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic              prod_valid = 1'b0;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data = '0;
  logic [BIAS_W-1:0] bias_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;
  logic              busy;

  int checks = 0;
  int failures = 0;

  myproject_dense_acc #(
    .N_IN(N_IN), .PROD_W(PROD_W), .ACC_W(ACC_W), .BIAS_W(BIAS_W),
    .BIAS_LSH(BIAS_LSH), .SHIFT(SHIFT), .OUT_W(OUT_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .bias_in(bias_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // The model keeps the accepted products of the current frame as a running
  // integer sum and a queue of results waiting to be taken downstream.
  bit     started = 0;
  longint part_sum = 0;
  int     part_cnt = 0;
  longint exp_d[$];
  bit     exp_s[$];
  bit     m_hold;
  longint m_sum;
  longint m_r;

  always @(negedge ap_clk) begin
    if (started) begin
      m_hold = (exp_d.size() != 0);
      chk("out_valid", out_valid, m_hold);
      chk("prod_ready", prod_ready, (!m_hold && !ap_rst));
      chk("busy", busy, (m_hold || part_cnt != 0));
      if (m_hold && out_valid) begin
        chk("out_data", $signed(out_data), exp_d[0]);
        chk("out_sat", out_sat, exp_s[0]);
      end
      if (ap_rst) begin
        part_sum = 0;
        part_cnt = 0;
        exp_d.delete();
        exp_s.delete();
      end else begin
        if (m_hold && out_ready) begin
          void'(exp_d.pop_front());
          void'(exp_s.pop_front());
        end
        if (!m_hold && prod_valid) begin
          part_sum += $signed(prod_data);
          part_cnt++;
          if (part_cnt == N_IN) begin
            m_sum = part_sum + $signed(bias_in) * (longint'(1) << BIAS_LSH);
            m_r   = (m_sum + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
            if (m_r > 32767) begin
              exp_d.push_back(32767); exp_s.push_back(1'b1);
            end else if (m_r < -32768) begin
              exp_d.push_back(-32768); exp_s.push_back(1'b1);
            end else begin
              exp_d.push_back(m_r); exp_s.push_back(1'b0);
            end
            part_sum = 0;
            part_cnt = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Send one product; non-handshake bias values are scrambled to show they are ignored.
  task automatic send(input longint p, input longint b, input bit is_last, input bit gaps);
    bit acc_ok;
    int n;
    logic [63:0] pv;
    logic [63:0] bv;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        prod_valid = 1'b0;
        prod_data  = PROD_W'($urandom);
        step();
      end
    end
    pv = p;
    bv = b;
    prod_valid = 1'b1;
    prod_data  = pv[PROD_W-1:0];
    bias_in    = is_last ? bv[BIAS_W-1:0] : BIAS_W'($urandom);
    acc_ok = 1'b0;
    n = 0;
    while (!acc_ok && n < 50) begin
      @(negedge ap_clk);
      acc_ok = prod_ready;
      step();
      n++;
    end
    if (!acc_ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic frame(input longint p0, input longint p1, input longint p2, input longint p3,
                       input longint b, input bit gaps, input bit lit,
                       input longint ed, input bit es);
    longint ps[4];
    int n;
    bit seen;
    ps[0] = p0; ps[1] = p1; ps[2] = p2; ps[3] = p3;
    for (int i = 0; i < 4; i++) send(ps[i], b, (i == 3), gaps);
    prod_valid = 1'b0;
    prod_data  = PROD_W'($urandom);
    bias_in    = BIAS_W'($urandom);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge ap_clk);
      n++;
      seen = out_valid;
    end
    if (!seen) chk("out_valid_timeout", 0, 1);
    else begin
      chk("latency", n, 1);
      if (lit) begin
        chk("lit_data", $signed(out_data), ed);
        chk("lit_sat", out_sat, es);
      end
    end
    step();
    if (out_ready) begin
      @(negedge ap_clk);
      chk("post_hs_valid", out_valid, 0);
      chk("post_hs_ready", prod_ready, 1);
      step();
    end
  endtask

  initial begin
    // reset
    step();
    started = 1;
    @(negedge ap_clk);
    chk("rst_data", out_data, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready_in_reset", prod_ready, 0);
    step();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("ready_after_rst", prod_ready, 1);
    step();

    // basic sum
    frame(1024, 1024, 1024, 1024, 0, 0, 1, 4, 0);
    // rounding
    frame(1536, 0, 0, 0, 0, 0, 1, 2, 0);
    frame(-1536, 0, 0, 0, 0, 0, 1, -1, 0);
    frame(511, 0, 0, 0, 0, 0, 1, 0, 0);
    frame(512, 0, 0, 0, 0, 0, 1, 1, 0);
    // saturation
    frame(1073741823, 1073741823, 1073741823, 1073741823, 0, 0, 1, 32767, 1);
    frame(-1073741824, -1073741824, -1073741824, -1073741824, 0, 0, 1, -32768, 1);
    frame(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // bias alignment
    frame(0, 0, 0, 0, 64, 0, 1, 1, 0);
    frame(0, 0, 0, 0, -96, 0, 1, -1, 0);
    // gappy valid
    frame(3000, -700, 12345, 2048, 5, 1, 1, 16, 0);
    for (int k = 0; k < 6; k++)
      frame($urandom_range(0, 2000000), -longint'($urandom_range(0, 2000000)),
            $urandom_range(0, 500000), -longint'($urandom_range(0, 500000)),
            $urandom_range(0, 200), 1, 0, 0, 0);

    // out_ready held low for 5 cycles
    out_ready = 1'b0;
    frame(2048, 2048, 0, 0, 0, 0, 1, 4, 0);
    for (int k = 0; k < 5; k++) begin
      prod_valid = 1'b1;
      prod_data  = PROD_W'($urandom);
      @(negedge ap_clk);
      chk("hold_data", $signed(out_data), 4);
      chk("hold_ready", prod_ready, 0);
      step();
    end
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    step();
    @(negedge ap_clk);
    chk("ready_after_hold", prod_ready, 1);
    step();

    // reset mid-accumulation
    send(1024, 0, 0, 0);
    send(1024, 0, 0, 0);
    prod_valid = 1'b0;
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    step();
    frame(1024, 1024, 1024, 1024, 0, 0, 1, 4, 0);

    // reset while a result is held
    out_ready = 1'b0;
    frame(4096, 0, 0, 0, 0, 0, 1, 4, 0);
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    out_ready = 1'b1;
    @(negedge ap_clk);
    chk("holdrst_valid", out_valid, 0);
    chk("holdrst_busy", busy, 0);
    step();
    frame(-2048, 0, 0, 0, 0, 0, 1, -2, 0);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
